// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, scan-phase encoding and boundary helper.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_e;

  // Each *_end is the first count value that belongs to the following phase.
  typedef struct packed {
    int act_end;
    int fp_end;
    int sync_end;
    int total;
  } bounds_t;

  function automatic bounds_t calc_bounds(input int active, input int front,
                                          input int sync_w, input int back);
    bounds_t b;
    b.act_end  = active;
    b.fp_end   = active + front;
    b.sync_end = b.fp_end + sync_w;
    b.total    = b.sync_end + back;
    return b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a programmable value.
module vga_delay_line #(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing master: scan counters, coordinate/request issue, and
// PIX_LAT-aligned sync/blank/colour towards the DAC.
//   state | meaning (same encoding for the H and V phase FSMs)
//   ACT   | visible pixels / lines
//   FP    | front porch
//   SYNC  | sync pulse asserted
//   BP    | back porch
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int PIX_LAT  = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_N,
  input  logic [9:0]          iRed,
  input  logic [9:0]          iGreen,
  input  logic [9:0]          iBlue,
  output logic [9:0]          oVGA_X,
  output logic [9:0]          oVGA_Y,
  output logic                oRequest,
  output logic                oFrameStart,
  output logic [9:0]          oVGA_R,
  output logic [9:0]          oVGA_G,
  output logic [9:0]          oVGA_B,
  output logic                oVGA_HS,
  output logic                oVGA_VS,
  output logic                oVGA_BLANK_N,
  output logic                oVGA_SYNC_N
);

  localparam bounds_t HB = calc_bounds(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam bounds_t VB = calc_bounds(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(HB.act_end - 1);
  localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(HB.fp_end - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(HB.sync_end - 1);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(HB.total - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(VB.act_end - 1);
  localparam logic [CNT_W-1:0] V_FP_LAST   = CNT_W'(VB.fp_end - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(VB.sync_end - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(VB.total - 1);

  // The phase FSMs step on the last count of each phase, so every phase needs at least one count.
  if (HB.total > CNT_MAX || VB.total > CNT_MAX) begin : g_err_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_err_lat
    $error("vga_sync_gen: PIX_LAT must be in 1..4");
  end
  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_err_phase
    $error("vga_sync_gen: every timing phase must be at least 1 long");
  end

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_end, v_end;
  phase_e           h_ph_q, h_ph_d;
  phase_e           v_ph_q, v_ph_d;

  always_comb begin
    h_end   = (h_cnt_q == H_LAST);
    v_end   = (v_cnt_q == V_LAST);
    h_cnt_d = h_end ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_end) begin
      v_cnt_d = v_end ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    h_ph_d = h_ph_q;
    case (h_ph_q)
      ACT:     if (h_cnt_q == H_ACT_LAST)  h_ph_d = FP;
      FP:      if (h_cnt_q == H_FP_LAST)   h_ph_d = SYNC;
      SYNC:    if (h_cnt_q == H_SYNC_LAST) h_ph_d = BP;
      BP:      if (h_end)                  h_ph_d = ACT;
      default:                             h_ph_d = ACT;
    endcase

    v_ph_d = v_ph_q;
    if (h_end) begin
      case (v_ph_q)
        ACT:     if (v_cnt_q == V_ACT_LAST)  v_ph_d = FP;
        FP:      if (v_cnt_q == V_FP_LAST)   v_ph_d = SYNC;
        SYNC:    if (v_cnt_q == V_SYNC_LAST) v_ph_d = BP;
        BP:      if (v_end)                  v_ph_d = ACT;
        default:                             v_ph_d = ACT;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_ph_q  <= ACT;
      v_ph_q  <= ACT;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_ph_q  <= h_ph_d;
      v_ph_q  <= v_ph_d;
    end
  end

  logic             req_q, req_d;
  logic             fs_q, fs_d;
  logic             hs_s0_q, hs_s0_d;
  logic             vs_s0_q, vs_s0_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;

  always_comb begin
    req_d   = (h_ph_q == ACT) && (v_ph_q == ACT);
    x_d     = req_d ? h_cnt_q : '0;
    y_d     = req_d ? v_cnt_q : '0;
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    hs_s0_d = (h_ph_q == SYNC);
    vs_s0_d = (v_ph_q == SYNC);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      hs_s0_q <= 1'b0;
      vs_s0_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      hs_s0_q <= hs_s0_d;
      vs_s0_q <= vs_s0_d;
    end
  end

  // Sync/active travel PIX_LAT clocks so they meet the colour returned for the same coordinate.
  logic hs_dl, vs_dl, act_dl;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL (3'b000)
  ) u_align (
    .iVGA_CLK (iVGA_CLK),
    .iRST_N   (iRST_N),
    .d        ({hs_s0_q, vs_s0_q, req_q}),
    .q        ({hs_dl, vs_dl, act_dl})
  );

  logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs_pin_q, hs_pin_d;
  logic       vs_pin_q, vs_pin_d;
  logic       blank_n_q, blank_n_d;

  always_comb begin
    r_d       = act_dl ? iRed   : '0;
    g_d       = act_dl ? iGreen : '0;
    b_d       = act_dl ? iBlue  : '0;
    hs_pin_d  = hs_dl ? SYNC_POL : !SYNC_POL;
    vs_pin_d  = vs_dl ? SYNC_POL : !SYNC_POL;
    blank_n_d = act_dl;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_pin_q  <= !SYNC_POL;
      vs_pin_q  <= !SYNC_POL;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_pin_q  <= hs_pin_d;
      vs_pin_q  <= vs_pin_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oRequest     = req_q;
  assign oFrameStart  = fs_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs_pin_q;
  assign oVGA_VS      = vs_pin_q;
  assign oVGA_BLANK_N = blank_n_q;
  assign oVGA_SYNC_N  = 1'b0;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing master for the VGA output path.
- Scans horizontal and vertical counters, presents pixel coordinates (oVGA_X/oVGA_Y) and a request strobe to downstream pattern generators, and accepts their 10-bit RGB back a fixed latency later.
- Delay-aligns HS/VS/BLANK with the returned colour, blanks RGB outside the active area, and drives the DAC-side pins.
- Sits between the pattern generators and the board VGA DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_LAT, 1, clocks from oVGA_X/Y valid to iRed/iGreen/iBlue valid (range 1..4)
- SYNC_POL, 0, sync polarity: 0 = active-low HS/VS, 1 = active-high

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST_N  in  1  asynchronous, active-low reset
- iRed  in  10  red from pattern generator, PIX_LAT after coordinate
- iGreen  in  10  green, same timing
- iBlue  in  10  blue, same timing
- oVGA_X  out  10  current column; 0 outside active area
- oVGA_Y  out  10  current row; 0 outside active area
- oRequest  out  1  high when oVGA_X/Y is an active pixel
- oFrameStart  out  1  one-clock pulse at h=0, v=0
- oVGA_R  out  10  red to DAC
- oVGA_G  out  10  green to DAC
- oVGA_B  out  10  blue to DAC
- oVGA_HS  out  1  horizontal sync
- oVGA_VS  out  1  vertical sync
- oVGA_BLANK_N  out  1  low during blanking
- oVGA_SYNC_N  out  1  tied 0 (no sync-on-green)

Behaviour:
- Reset (async, any time including mid-frame):
  - h_cnt = v_cnt = 0; delay line cleared to blank.
  - oVGA_X/Y/R/G/B = 0; oRequest = 0; oFrameStart = 0; oVGA_BLANK_N = 0.
  - oVGA_HS/VS = inactive level (1 when SYNC_POL = 0).
  - Scan restarts from frame start after release.
- Counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise. Both must be ≤ 1024 (10-bit counters); elaborate-time error otherwise.
  - h_cnt increments every clock and wraps H_TOTAL-1 → 0.
  - v_cnt increments only on the h wrap, and wraps V_TOTAL-1 → 0.
  - Line-end and frame-end wraps in the same clock set both counters to 0 together.
- Phase FSMs, one each for H and V, states ACT → FP → SYNC → BP → ACT:
  - H transitions when h_cnt reaches the phase boundary: H_ACTIVE, +H_FRONT, +H_SYNC, H_TOTAL.
  - V transitions identically, but only on line ends.
- Stage 0 (registered from counters):
  - oRequest = (H==ACT && V==ACT).
  - oVGA_X = h_cnt and oVGA_Y = v_cnt when oRequest, else 0.
  - oFrameStart = (h_cnt==0 && v_cnt==0).
- Alignment:
  - Raw hs, vs and active are pushed through a PIX_LAT-deep shift register, then one output register stage.
  - oVGA_* therefore corresponds to the coordinate issued PIX_LAT+1 clocks earlier.
- Colour:
  - oVGA_R/G/B = iRed/iGreen/iBlue registered when the delayed active bit = 1, else 0.
  - RGB input during blanking is ignored.
- Sync:
  - oVGA_HS is asserted (polarity per SYNC_POL) exactly H_SYNC clocks per line.
  - oVGA_VS is asserted exactly V_SYNC*H_TOTAL clocks per frame and changes only at line boundaries (delayed h_cnt = 0).
  - oVGA_BLANK_N = delayed active.
- No backpressure: the pattern side must meet PIX_LAT every clock.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants.
  - Phase enum {ACT, FP, SYNC, BP}.
  - Helper function computing totals and phase boundaries.
- Sub-module vga_delay_line: parameterised width/depth shift register with async clear to a reset value. Used for the PIX_LAT sync/blank alignment.

Test Plan:
- Small config (H 8/2/3/2 → total 15; V 4/1/1/1 → total 7; PIX_LAT = 1), after reset release:
  - oRequest is high for 8 consecutive clocks, with oVGA_X = 0..7 and oVGA_Y = 0.
  - Then oRequest is low for 7 clocks with X = Y = 0.
- Same config, HS timing:
  - oVGA_HS falls 12 clocks after the first X = 0 (10 + 2 latency) and stays low 3 clocks.
  - Falling-edge period is 15 clocks.
- Same config, frame timing:
  - oVGA_VS is low for exactly 15 clocks per frame.
  - oFrameStart period is 105 clocks.
  - oVGA_BLANK_N high count per frame is 32.
- Pattern model returning iBlue = 512, iRed = iGreen = 0 with 1-clock latency:
  - oVGA_B = 512 exactly when BLANK_N = 1, and 0 otherwise.
  - Repeat with PIX_LAT = 3 and a 3-clock model; alignment still holds.
- Drive iRST_N low at h = 5, v = 2 for 3 clocks:
  - All outputs reach reset values immediately (asynchronously).
  - After release, first oVGA_X = 0, Y = 0 and oFrameStart = 1.
- Default 640x480:
  - HS period 800, HS low 96.
  - VS low 1600 clocks; frame 420000 clocks.
  - 307200 active pixels per frame.
